// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable tick divider with square-wave output and one-shot mode.
module tick_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 24,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = '1,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] done,
  output logic              cfg_ack
);
  logic [CNT_W-1:0] div [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0] mode;
  logic wr_ok;
  assign wr_ok = cfg_we && (32'(cfg_ch) < NUM_CH);
  // a write to a channel beats its terminal count on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        div[c] <= DEFAULT_DIV;
        cnt[c] <= '0;
      end
      mode <= '0;
      tick <= '0;
      sq <= '0;
      done <= '0;
      cfg_ack <= 1'b0;
    end else begin
      cfg_ack <= wr_ok;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ok && cfg_ch == CH_W'(c)) begin
          div[c] <= cfg_div;
          mode[c] <= cfg_mode;
          cnt[c] <= '0;
          tick[c] <= 1'b0;
          done[c] <= 1'b0;
        end else if (!ch_en[c] || done[c]) begin
          cnt[c] <= '0;
          tick[c] <= 1'b0;
          done[c] <= done[c] && ch_en[c];
        end else if (cnt[c] == div[c]) begin
          cnt[c] <= '0;
          tick[c] <= 1'b1;
          sq[c] <= ~sq[c];
          done[c] <= mode[c];
        end else begin
          cnt[c] <= cnt[c] + 1'b1;
          tick[c] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed stimulus with tick/ack scoreboard queues drained by a negedge monitor.
module tb_tick_gen;
  localparam int NCH = 3;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic cfg_mode = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [CW-1:0] cfg_div = '0;
  logic [NCH-1:0] ch_en = '0;
  logic [NCH-1:0] tick, sq, done;
  logic cfg_ack;
  int cyc = 0;
  int n_chk = 0;
  int n_bad = 0;
  int tq [NCH][$];
  int aq [$];

  tick_gen #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode), .ch_en(ch_en), .tick(tick), .sq(sq), .done(done), .cfg_ack(cfg_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int e, input int s);
    tq[c].push_back(e * 2 + s);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [CW-1:0] d, input logic m,
                    input logic [NCH-1:0] en, output int w);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_div = d;
    cfg_mode = m;
    ch_en = en;
    w = cyc + 1;
    if (int'(ch) < NCH) aq.push_back(w);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  always @(negedge clk) begin
    int e;
    for (int c = 0; c < NCH; c++) begin
      if (tick[c]) begin
        if (tq[c].size() == 0) chk($sformatf("tick%0d_unexpected", c), cyc, -1);
        else begin
          e = tq[c].pop_front();
          chk($sformatf("tick%0d_cycle", c), cyc, e / 2);
          chk($sformatf("sq%0d_at_tick", c), int'(sq[c]), e % 2);
        end
      end
    end
    if (cfg_ack) begin
      if (aq.size() == 0) chk("ack_unexpected", cyc, -1);
      else begin
        e = aq.pop_front();
        chk("ack_cycle", cyc, e);
      end
    end
  end

  initial begin
    int w0, w1, t, w2, we, r;
    repeat (3) @(negedge clk);
    chk("rst_tick", int'(tick), 0);
    chk("rst_sq", int'(sq), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ack", int'(cfg_ack), 0);
    rst_n = 1'b1;
    @(negedge clk);
    wr(2'd0, 8'd3, 1'b0, 3'b001, w0);
    for (int k = 1; k <= 7; k++) push(0, w0 + 4 * k, k % 2);
    repeat (2) @(negedge clk);
    wr(2'd1, 8'd0, 1'b0, 3'b011, w1);
    for (int k = 1; k <= 8; k++) push(1, w1 + k, k % 2);
    repeat (8) @(negedge clk);
    ch_en = 3'b001;
    repeat (20) @(negedge clk);
    wr(2'd0, 8'd3, 1'b0, 3'b001, t);
    push(0, t + 4, 0);
    push(0, t + 8, 1);
    repeat (8) @(negedge clk);
    wr(2'd2, 8'd5, 1'b1, 3'b000, w2);
    ch_en = 3'b100;
    push(2, w2 + 6, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("done2_oneshot", int'(done[2]), int'(cyc >= w2 + 6));
    end
    ch_en = 3'b000;
    @(negedge clk);
    chk("done2_clear", int'(done[2]), 0);
    wr(2'd3, 8'd1, 1'b1, 3'b000, we);
    ch_en = 3'b001;
    push(0, we + 4, 0);
    push(0, we + 8, 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_sq", int'(sq), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_ack", int'(cfg_ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    push(0, r + 256, 1);
    repeat (260) @(negedge clk);
    for (int c = 0; c < NCH; c++) chk($sformatf("tick%0d_missing", c), tq[c].size(), 0);
    chk("ack_missing", aq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
